regfile_read_arbiter: RTL and testbench

Shares a single 32-entry x 32-bit read mux (5-bit address, 32-bit data) among NUM_REQ requesters. Arbitrates round-robin, drives the mux address from a register, and captures the selected word. Returns the word with the requester ID over a valid/ready response channel. Sits between client units (ALU operand fetch, debug port, etc.) and the register-file read mux.

---
 rtl/regfile_read_arbiter_pkg.sv | 36 +++
 rtl/regfile_read_arbiter_if.sv | 57 +++++
 rtl/regfile_read_arbiter_rr_grant.sv | 69 ++++++
 rtl/regfile_read_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_read_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter_pkg
// Description : Shared widths, FSM state encoding and a small index helper
//               for the register-file read arbiter.
// Config      : ARB_FIXED_PRIO_EN (fixed-priority grant instead of round-robin)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_read_arbiter_pkg;

  // Width of a register-file address (32 entries).
  localparam int ADDR_W = 5;
  // Width of a register-file word.
  localparam int DATA_W = 32;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Adds an offset to a requester index and wraps it into 0..n-1.
  // The caller guarantees base < n and off <= n, so a single subtraction
  // is enough to bring the sum back into range.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

endpackage : regfile_read_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter_if
// Description : Request, register-file mux and response signals of the read
//               arbiter. The slave modport is the arbiter; the master modport
//               is the surrounding system (clients, mux and response sink).
// Config      : ARB_FIXED_PRIO_EN (no effect on this interface)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_read_arbiter_if
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  // Request channel: one valid/ready pair and one packed address per client.
  logic [NUM_REQ-1:0]        req_valid;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;

  // Shared 32:1 register-file read mux.
  logic [ADDR_W-1:0]         mux_address;
  logic [DATA_W-1:0]         mux_data;

  // Response channel back to the client side.
  logic                      resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic [ID_W-1:0]           resp_id;
  logic                      resp_ready;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  mux_address,
    output mux_data,
    input  resp_valid,
    input  resp_data,
    input  resp_id,
    output resp_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output mux_address,
    input  mux_data,
    output resp_valid,
    output resp_data,
    output resp_id,
    input  resp_ready
  );

endinterface : regfile_read_arbiter_if
`default_nettype wire

// File: rtl/regfile_read_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Purely combinational grant selector. Produces a one-hot grant
//               and its encoded index from the request vector.
//               Default: round-robin, searching upward from last_grant+1 with
//               wrap modulo NUM_REQ.
// Config      : ARB_FIXED_PRIO_EN - lowest-indexed valid requester always
//               wins; the last_grant input is then absent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    i_last_grant,
`endif
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

`ifdef ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top down so the lowest valid index is the
  // last one written and therefore wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        o_grant     = '0;
        o_grant[i]  = 1'b1;
        o_grant_idx = ID_W'(i);
        o_any       = 1'b1;
      end
    end
  end

`else

  // Round-robin: candidate k steps past the last winner. Scanning k from the
  // farthest back to the nearest lets the closest valid candidate win.
  always_comb begin
    int w_idx;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = wrap_add(int'(i_last_grant), k, NUM_REQ);
      if (i_req_valid[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = ID_W'(w_idx);
        o_any          = 1'b1;
      end
    end
  end

`endif

endmodule : rr_grant
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_arbiter
// Description : Shares one 32x32 register-file read mux among NUM_REQ
//               clients. A granted request loads the mux address, the next
//               cycle captures the mux word, and the word is then offered on
//               a valid/ready response channel tagged with the client index.
//               Phases: IDLE -> READ -> RESP -> IDLE.
// Config      : ARB_FIXED_PRIO_EN - fixed lowest-index priority instead of
//               round-robin; timing is identical in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_read_arbiter_if.slave  bus,
  output logic                   busy
);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_mux_address;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [ID_W-1:0]     r_resp_id;
  logic                r_busy;
`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     r_last_grant;
`endif

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_take;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .i_req_valid  (bus.req_valid),
`ifndef ARB_FIXED_PRIO_EN
    .i_last_grant (r_last_grant),
`endif
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  // A grant is only offered while idle; in READ/RESP all readies stay low so
  // a request that comes and goes during a transaction leaves no trace.
  assign w_take        = (r_state == IDLE) && w_any;
  assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;

  // Pick the granted client's address slice with a one-hot AND-OR mux.
  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM with registered outputs. mux_address moves only on a
  // grant edge or reset; the response is held until the sink accepts it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mux_address <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_id     <= '0;
      r_busy        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_grant  <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_mux_address <= w_sel_addr;
            r_resp_id     <= w_grant_idx;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant  <= w_grant_idx;
`endif
            r_busy        <= 1'b1;
            r_state       <= READ;
          end
        end
        READ: begin
          r_resp_data  <= bus.mux_data;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.mux_address = r_mux_address;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_data   = r_resp_data;
  assign bus.resp_id     = r_resp_id;
  assign busy            = r_busy;

endmodule : regfile_read_arbiter
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_read_arbiter
// Description : Self-checking bench for regfile_read_arbiter. Directed
//               scenarios followed by randomized traffic, all compared
//               against a transaction-level reference model.
// Config      : ARB_FIXED_PRIO_EN (expected grant order follows the build)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_arbiter;
  import regfile_read_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_read_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  regfile_read_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Register-file read mux model.
  always_comb bus.mux_data = rf[bus.mux_address];

  // --------------------------------------------------------------------------
  // Reference model: one outstanding read. m_phase counts progress of the
  // read (0 no read, 1 address presented, 2 word offered).
  // --------------------------------------------------------------------------
  int          m_phase;
  int          m_last;
  logic [4:0]  m_addr;
  int          m_id;
  logic [31:0] m_data;
  bit          m_rv;

  int          glog_idx [$];
  int          glog_cyc [$];
  int          cyc = 0;
  logic [3:0]  obs_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic logic [19:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = N - 1;
    m_addr  = '0;
    m_id    = 0;
    m_data  = '0;
    m_rv    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare every output, advance the model.
  task automatic step(input logic [3:0] v, input logic [19:0] a, input logic rr, input logic rs);
    logic [3:0] exp_rdy;
    int g;
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.resp_ready = rr;
    reset          = rs;
    #1;
    exp_rdy = '0;
    g = -1;
    if (m_phase == 0) begin
      g = pick(v);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    obs_rdy = bus.req_ready;
    check_eq("req_ready",   32'(obs_rdy),          32'(exp_rdy));
    check_eq("mux_address", 32'(bus.mux_address),  32'(m_addr));
    check_eq("resp_valid",  32'(bus.resp_valid),   32'(m_rv));
    check_eq("resp_data",   bus.resp_data,         m_data);
    check_eq("resp_id",     32'(bus.resp_id),      32'(m_id));
    check_eq("busy",        32'(busy),             32'(m_phase != 0));
    for (int i = 0; i < N; i++) begin
      if (obs_rdy[i]) begin
        glog_idx.push_back(i);
        glog_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        m_addr  = a[g*5 +: 5];
        m_id    = g;
        m_last  = g;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data  = rf[m_addr];
      m_rv    = 1'b1;
      m_phase = 2;
    end else if (rr) begin
      m_rv    = 1'b0;
      m_phase = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 20'd0, 1'b1, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int          exp_id;
    logic [31:0] exp_word;
    logic [31:0] w31;
    logic [31:0] w0;
    int          n2;

    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD0000 | 32'(i);
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state.
    @(negedge clk);
    #1;
    check_eq("rst_busy",       32'(busy),            32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid),  32'd0);
    check_eq("rst_mux_addr",   32'(bus.mux_address), 32'd0);
    check_eq("rst_req_ready",  32'(bus.req_ready),   32'd0);
    check_eq("rst_resp_id",    32'(bus.resp_id),     32'd0);
    check_eq("rst_resp_data",  bus.resp_data,        32'd0);

    // Single request from client 1 at address 7.
    step(4'b0010, pack(0, 7, 0, 0), 1'b0, 1'b0);
    check_eq("single_ready", 32'(obs_rdy), 32'h2);
    step(4'b0000, 20'd0, 1'b0, 1'b0);
    check_eq("single_mux_addr", 32'(bus.mux_address), 32'd7);
    step(4'b0000, 20'd0, 1'b0, 1'b0);
    check_eq("single_resp_valid", 32'(bus.resp_valid), 32'd1);
    check_eq("single_resp_data",  bus.resp_data,       32'hDEAD0007);
    check_eq("single_resp_id",    32'(bus.resp_id),    32'd1);
    step(4'b0000, 20'd0, 1'b1, 1'b0);

    // Fairness: everybody requesting, sink always ready.
    step(4'b0000, 20'd0, 1'b1, 1'b1);
    glog_idx.delete();
    glog_cyc.delete();
    for (int i = 0; i < 18; i++) step(4'hF, pack(1, 2, 3, 4), 1'b1, 1'b0);
    check_eq("fair_count", 32'(glog_idx.size()), 32'd6);
    if (glog_idx.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        check_eq("fair_order", 32'(glog_idx[k]), 32'd0);
`else
        check_eq("fair_order", 32'(glog_idx[k]), 32'(k % 4));
`endif
        if (k > 0) check_eq("fair_spacing", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd3);
      end
    end

    // Backpressure: sink stalls for 5 cycles after resp_valid.
`ifdef ARB_FIXED_PRIO_EN
    exp_id = 0;
`else
    exp_id = 2;
`endif
    exp_word = rf[exp_id + 1];
    glog_idx.delete();
    glog_cyc.delete();
    step(4'hF, pack(1, 2, 3, 4), 1'b0, 1'b0);
    step(4'hF, pack(1, 2, 3, 4), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'hF, pack(1, 2, 3, 4), 1'b0, 1'b0);
      check_eq("bp_resp_data",  bus.resp_data,      exp_word);
      check_eq("bp_resp_id",    32'(bus.resp_id),   32'(exp_id));
      check_eq("bp_req_ready",  32'(obs_rdy),       32'd0);
    end
    check_eq("bp_one_grant", 32'(glog_idx.size()), 32'd1);
    step(4'hF, pack(1, 2, 3, 4), 1'b1, 1'b0);
    check_eq("bp_release_valid", 32'(bus.resp_valid), 32'd1);
    step(4'hF, pack(1, 2, 3, 4), 1'b1, 1'b0);
    check_eq("bp_after_valid", 32'(bus.resp_valid), 32'd0);
`ifdef ARB_FIXED_PRIO_EN
    check_eq("bp_next_grant", 32'(obs_rdy), 32'h1);
`else
    check_eq("bp_next_grant", 32'(obs_rdy), 32'h8);
`endif
    idle(3);

    // Boundary addresses: client 3 reads 31, then client 0 reads 0.
    w31 = $urandom;
    w0  = $urandom | 32'h1;
    rf[31] = w31;
    rf[0]  = w0;
    step(4'b1000, pack(0, 0, 0, 31), 1'b1, 1'b0);
    step(4'b0000, 20'd0, 1'b1, 1'b0);
    check_eq("bnd_mux_31", 32'(bus.mux_address), 32'd31);
    step(4'b0000, 20'd0, 1'b1, 1'b0);
    check_eq("bnd_data_31", bus.resp_data, w31);
    step(4'b0001, pack(0, 0, 0, 0), 1'b1, 1'b0);
    step(4'b0000, 20'd0, 1'b1, 1'b0);
    check_eq("bnd_mux_0", 32'(bus.mux_address), 32'd0);
    step(4'b0000, 20'd0, 1'b1, 1'b0);
    check_eq("bnd_data_0", bus.resp_data, w0);
    idle(2);

    // Reset during READ aborts the read.
    step(4'b0010, pack(0, 9, 0, 0), 1'b0, 1'b0);
    step(4'b0000, 20'd0, 1'b0, 1'b1);
    step(4'b0000, 20'd0, 1'b0, 1'b0);
    check_eq("abort_valid", 32'(bus.resp_valid),  32'd0);
    check_eq("abort_busy",  32'(busy),            32'd0);
    check_eq("abort_mux",   32'(bus.mux_address), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 20'd0, 1'b0, 1'b0);
      check_eq("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    step(4'hF, pack(3, 4, 5, 6), 1'b1, 1'b0);
    check_eq("abort_first_grant", 32'(obs_rdy), 32'h1);
    idle(3);

    // Withdrawn request: client 2 pulses valid while a response is held.
    glog_idx.delete();
    glog_cyc.delete();
    step(4'b0001, pack(12, 0, 0, 0), 1'b0, 1'b0);
    step(4'b0000, 20'd0, 1'b0, 1'b0);
    step(4'b0100, pack(0, 0, 20, 0), 1'b0, 1'b0);
    step(4'b0000, 20'd0, 1'b1, 1'b0);
    idle(4);
    n2 = 0;
    foreach (glog_idx[k]) if (glog_idx[k] == 2) n2++;
    check_eq("withdraw_grants", 32'(glog_idx.size()), 32'd1);
    check_eq("withdraw_no_req2", 32'(n2), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0]  v;
      logic [19:0] a;
      logic        rr;
      logic        rs;
      v  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) v = 4'b0001 << $urandom_range(0, 3);
      a  = 20'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 99) == 0);
      step(v, a, rr, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_read_arbiter
`default_nettype wire
